// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger lane block: game states, screen width and coordinate widths.
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HIT  = 2'd1,
        ST_WIN  = 2'd2
    } state_e;

    localparam int unsigned H_RES   = 640;
    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned SCORE_W = 8;

    // Bit positions of the button pair in the synchroniser / pending vectors
    localparam int unsigned BTN_UP = 0;
    localparam int unsigned BTN_DN = 1;

endpackage

// File: rtl/lane_obstacle.sv
// One obstacle lane: wrapping horizontal position and the per-pixel obstacle test.
module lane_obstacle
    import frogger_pkg::*;
#(
    parameter int unsigned LANE_IDX   = 0,
    parameter int unsigned SPEED_BASE = 1,
    parameter int unsigned LANE_H     = 40,
    parameter int unsigned ROW0_Y     = 420,
    parameter int unsigned OBS_W      = 64
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_step,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    output logic           o_hit_c
);

    localparam int unsigned    SPEED      = SPEED_BASE * (LANE_IDX + 1);
    localparam int unsigned    TOP        = ROW0_Y - (LANE_IDX + 1) * LANE_H;
    localparam bit             MOVE_RIGHT = (LANE_IDX % 2) == 0;
    localparam logic [X_W:0]   HRES_X     = (X_W+1)'(H_RES);
    localparam logic [X_W:0]   SPEED_X    = (X_W+1)'(SPEED);
    localparam logic [X_W:0]   OBS_X      = (X_W+1)'(OBS_W);
    localparam logic [X_W-1:0] CX_INIT    = X_W'((LANE_IDX * 160) % H_RES);
    localparam logic [Y_W-1:0] Y_LO       = Y_W'(TOP);
    localparam logic [Y_W-1:0] Y_HI       = Y_W'(TOP + LANE_H - 1);

    logic [X_W-1:0] cx_q, cx_d;
    logic [X_W:0]   cx_ext, x_ext, fwd, dx;

    assign cx_ext = {1'b0, cx_q};
    assign x_ext  = {1'b0, i_x};
    assign fwd    = cx_ext + SPEED_X;

    // Advance by one speed step with wrap at the screen width
    always_comb begin
        cx_d = cx_q;
        if (i_step) begin
            if (MOVE_RIGHT) begin
                cx_d = (fwd >= HRES_X) ? X_W'(fwd - HRES_X) : X_W'(fwd);
            end else begin
                cx_d = (cx_ext < SPEED_X) ? X_W'(cx_ext + HRES_X - SPEED_X)
                                          : X_W'(cx_ext - SPEED_X);
            end
        end
    end

    // Obstacle spans OBS_W pixels to the right of cx, wrapping across the screen edge
    always_comb begin
        dx      = (i_x >= cx_q) ? (x_ext - cx_ext) : (x_ext + HRES_X - cx_ext);
        o_hit_c = (i_y >= Y_LO) && (i_y <= Y_HI) && (dx < OBS_X);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cx_q <= CX_INIT;
        end else begin
            cx_q <= cx_d;
        end
    end

endmodule

// File: rtl/frogger_lanes.sv
// Frogger playfield: obstacle lanes, frog position, button handling, game FSM and score.
module frogger_lanes
    import frogger_pkg::*;
#(
    parameter int unsigned N_LANES     = 4,
    parameter int unsigned LANE_H      = 40,
    parameter int unsigned ROW0_Y      = 420,
    parameter int unsigned OBS_W       = 64,
    parameter int unsigned SPEED_BASE  = 1,
    parameter int unsigned FROG_X      = 312,
    parameter int unsigned FROG_W      = 16,
    parameter int unsigned HOLD_FRAMES = 60
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_stb,
    input  logic               i_animate,
    input  logic [X_W-1:0]     i_x,
    input  logic [Y_W-1:0]     i_y,
    input  logic               i_up_btn,
    input  logic               i_down_btn,
    output logic [N_LANES-1:0] o_obj,
    output logic               o_frog,
    output logic [1:0]         o_state,
    output logic [SCORE_W-1:0] o_score
);

    localparam int unsigned    CNT_W     = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_LANES);
    localparam logic [X_W-1:0] FX_LO     = X_W'(FROG_X);
    localparam logic [X_W-1:0] FX_HI     = X_W'(FROG_X + FROG_W - 1);
    localparam logic [Y_W:0]   FY0       = (Y_W+1)'(ROW0_Y + (LANE_H - FROG_W) / 2);
    localparam logic [Y_W:0]   LANE_H_Y  = (Y_W+1)'(LANE_H);
    localparam logic [Y_W:0]   FW_M1     = (Y_W+1)'(FROG_W - 1);

    state_e               state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [1:0]           sync1_q, sync2_q, prev_q, pend_q, pend_d;
    logic                 col_q, col_d;
    logic [N_LANES-1:0]   obj_q, obj_d, obj_c;
    logic                 frog_q, frog_d, frog_c;
    logic [1:0]           rise_c;
    logic                 move_up_c, move_dn_c, lane_step_c;
    logic [Y_W:0]         fy_lo_c, fy_hi_c, y_ext_c;

    assign lane_step_c = i_animate && (state_q == ST_PLAY);

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        lane_obstacle #(
            .LANE_IDX   (k),
            .SPEED_BASE (SPEED_BASE),
            .LANE_H     (LANE_H),
            .ROW0_Y     (ROW0_Y),
            .OBS_W      (OBS_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_step  (lane_step_c),
            .i_x     (i_x),
            .i_y     (i_y),
            .o_hit_c (obj_c[k])
        );
    end

    // Frog square sits vertically centred in its row
    assign y_ext_c = {1'b0, i_y};
    assign fy_lo_c = FY0 - ((Y_W+1)'(row_q) * LANE_H_Y);
    assign fy_hi_c = fy_lo_c + FW_M1;
    assign frog_c  = (i_x >= FX_LO) && (i_x <= FX_HI) &&
                     (y_ext_c >= fy_lo_c) && (y_ext_c <= fy_hi_c);

    assign rise_c    = sync2_q & ~prev_q;
    assign move_up_c = pend_q[BTN_UP] && !pend_q[BTN_DN];
    assign move_dn_c = pend_q[BTN_DN] && !pend_q[BTN_UP] && (row_q != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Collision is judged on the flag accumulated over the frame, before any move
    always_comb begin
        state_d = state_q;
        if (i_animate) begin
            case (state_q)
                ST_PLAY: begin
                    if (col_q) begin
                        state_d = ST_HIT;
                    end else if (move_up_c && (row_q == LAST_ROW)) begin
                        state_d = ST_WIN;
                    end
                end
                ST_HIT, ST_WIN: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_PLAY;
                    end
                end
                default: state_d = ST_PLAY;
            endcase
        end
    end

    always_comb begin
        row_d   = row_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        pend_d  = pend_q | rise_c;
        col_d   = col_q | (i_pix_stb & frog_c & (|obj_c));
        obj_d   = obj_q;
        frog_d  = frog_q;
        if (i_pix_stb) begin
            obj_d  = obj_c;
            frog_d = frog_c;
        end
        if (i_animate) begin
            pend_d = rise_c;
            col_d  = 1'b0;
            if (state_q == ST_PLAY) begin
                if (!col_q && move_up_c) begin
                    row_d = row_q + 1'b1;
                    if ((row_q == LAST_ROW) && (score_q != '1)) begin
                        score_d = score_q + 1'b1;
                    end
                end else if (!col_q && move_dn_c) begin
                    row_d = row_q - 1'b1;
                end
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                row_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            row_q   <= '0;
            cnt_q   <= '0;
            score_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            col_q   <= 1'b0;
            obj_q   <= '0;
            frog_q  <= 1'b0;
        end else begin
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            sync1_q <= {i_down_btn, i_up_btn};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
            col_q   <= col_d;
            obj_q   <= obj_d;
            frog_q  <= frog_d;
        end
    end

    assign o_obj   = obj_q;
    assign o_frog  = frog_q;
    assign o_state = state_q;
    assign o_score = score_q;

endmodule

// File: tb/tb_frogger_lanes.sv
// Bench for frogger_lanes: frame-level game model, per-cycle output compare, directed literal checks.
module tb_frogger_lanes;

    localparam int NL = 4, LH = 40, R0 = 420, OW = 64, SB = 1, FX = 312, FW = 16, HOLD = 60;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, pix_stb = 1'b0, animate = 1'b0, up_btn = 1'b0, down_btn = 1'b0;
    logic [9:0]    x = '0;
    logic [8:0]    y = '0;
    logic [NL-1:0] obj;
    logic          frog;
    logic [1:0]    state;
    logic [7:0]    score;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int        m_cx[NL];
    int        m_row, m_state, m_score, m_cnt;
    bit        m_pu, m_pd, m_col, m_frog, m_up_lvl, m_dn_lvl;
    bit [NL-1:0] m_obj;

    always #5 clk = ~clk;

    frogger_lanes #(
        .N_LANES(NL), .LANE_H(LH), .ROW0_Y(R0), .OBS_W(OW), .SPEED_BASE(SB),
        .FROG_X(FX), .FROG_W(FW), .HOLD_FRAMES(HOLD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_animate(animate),
        .i_x(x), .i_y(y), .i_up_btn(up_btn), .i_down_btn(down_btn),
        .o_obj(obj), .o_frog(frog), .o_state(state), .o_score(score)
    );

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit lane_px(int k, int px, int py, int c);
        int top = R0 - (k + 1) * LH;
        return (py >= top) && (py < top + LH) && (((px - c + 640) % 640) < OW);
    endfunction

    function automatic bit frog_px(int px, int py, int row);
        int top = R0 - row * LH + (LH - FW) / 2;
        return (px >= FX) && (px < FX + FW) && (py >= top) && (py < top + FW);
    endfunction

    // One clock: derive next model state from current inputs, commit it at the edge
    task automatic step();
        int n_cx[NL];
        int n_row, n_state, n_score, n_cnt, spd;
        bit n_pu, n_pd, n_col, n_frog;
        bit [NL-1:0] n_obj, hits;
        bit fh;
        n_cx = m_cx; n_row = m_row; n_state = m_state; n_score = m_score; n_cnt = m_cnt;
        n_pu = m_pu; n_pd = m_pd; n_col = m_col; n_frog = m_frog; n_obj = m_obj;
        for (int k = 0; k < NL; k++) hits[k] = lane_px(k, int'(x), int'(y), m_cx[k]);
        fh = frog_px(int'(x), int'(y), m_row);
        if (!rst_n) begin
            for (int k = 0; k < NL; k++) n_cx[k] = (k * 160) % 640;
            n_row = 0; n_state = 0; n_score = 0; n_cnt = 0;
            n_pu = 0; n_pd = 0; n_col = 0; n_frog = 0; n_obj = '0;
        end else begin
            if (pix_stb) begin
                n_obj = hits; n_frog = fh;
                if (fh && hits != '0) n_col = 1;
            end
            if (animate) begin
                n_col = 0; n_pu = 0; n_pd = 0;
                if (m_state == 0) begin
                    for (int k = 0; k < NL; k++) begin
                        spd = SB * (k + 1);
                        n_cx[k] = (k % 2 == 0) ? (m_cx[k] + spd) % 640 : (m_cx[k] - spd + 640) % 640;
                    end
                    if (m_col) n_state = 1;
                    else if (m_pu && !m_pd) begin
                        n_row = m_row + 1;
                        if (n_row == NL + 1) begin
                            n_state = 2;
                            if (m_score < 255) n_score = m_score + 1;
                        end
                    end else if (m_pd && !m_pu && m_row > 0) n_row = m_row - 1;
                end else begin
                    n_cnt = m_cnt + 1;
                    if (n_cnt == HOLD) begin n_state = 0; n_row = 0; n_cnt = 0; end
                end
            end
        end
        @(posedge clk);
        m_cx = n_cx; m_row = n_row; m_state = n_state; m_score = n_score; m_cnt = n_cnt;
        m_pu = n_pu; m_pd = n_pd; m_col = n_col; m_frog = n_frog; m_obj = n_obj;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("o_obj", int'(obj), int'(m_obj));
            cmp("o_frog", int'(frog), int'(m_frog));
            cmp("o_state", int'(state), m_state);
            cmp("o_score", int'(score), m_score);
        end
    end

    task automatic set_btn(input bit u, input bit d);
        if (u && !m_up_lvl) m_pu = 1;
        if (d && !m_dn_lvl) m_pd = 1;
        m_up_lvl = u; m_dn_lvl = d;
        up_btn = u; down_btn = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic anim();
        animate = 1'b1; step(); animate = 1'b0; step();
    endtask

    task automatic anims(input int n);
        repeat (n) anim();
    endtask

    task automatic pix(input int px, input int py);
        pix_stb = 1'b1; x = 10'(px); y = 9'(py); step(); pix_stb = 1'b0;
    endtask

    task automatic press(input bit u, input bit d);
        set_btn(u, d); idle(3); set_btn(0, 0); idle(3); anim();
    endtask

    task automatic reset_dut();
        set_btn(0, 0); pix_stb = 1'b0; animate = 1'b0;
        idle(3);
        rst_n = 1'b0; step(); chk_en = 1'b1; step();
        rst_n = 1'b1; step();
    endtask

    initial begin
        for (int k = 0; k < NL; k++) m_cx[k] = 0;
        m_row = 0; m_state = 0; m_score = 0; m_cnt = 0;
        m_pu = 0; m_pd = 0; m_col = 0; m_frog = 0; m_obj = '0; m_up_lvl = 0; m_dn_lvl = 0;
        idle(2);
        reset_dut();
        cmp("rst_state", int'(state), 0);
        cmp("rst_score", int'(score), 0);
        cmp("rst_obj", int'(obj), 0);
        cmp("rst_frog", int'(frog), 0);

        // First frame geometry
        anim();
        pix(1, 380);   cmp("l0_x1", int'(obj[0]), 1);
        pix(0, 380);   cmp("l0_x0", int'(obj[0]), 0);
        pix(158, 340); cmp("l1_x158", int'(obj[1]), 1);
        pix(221, 340); cmp("l1_x221", int'(obj[1]), 1);
        pix(157, 340); cmp("l1_x157", int'(obj[1]), 0);
        pix(222, 340); cmp("l1_x222", int'(obj[1]), 0);
        pix(312, 432); cmp("frog_tl", int'(frog), 1);
        pix(311, 432); cmp("frog_left", int'(frog), 0);
        pix(327, 447); cmp("frog_br", int'(frog), 1);
        pix(312, 448); cmp("frog_below", int'(frog), 0);

        // Lane 1 wraps leftward through 0
        anims(79);
        pix(0, 340);   cmp("l1_cx0", int'(obj[1]), 1);
        pix(639, 340); cmp("l1_cx0_prev", int'(obj[1]), 0);
        anim();
        pix(638, 340); cmp("l1_wrap638", int'(obj[1]), 1);
        pix(637, 340); cmp("l1_wrap637", int'(obj[1]), 0);
        pix(61, 340);  cmp("l1_wrapspan", int'(obj[1]), 1);

        // Lane 0 reaches 639 then wraps to 0
        anims(558);
        pix(639, 380); cmp("l0_cx639", int'(obj[0]), 1);
        pix(638, 380); cmp("l0_cx639_prev", int'(obj[0]), 0);
        pix(62, 380);  cmp("l0_span_end", int'(obj[0]), 1);
        pix(63, 380);  cmp("l0_span_out", int'(obj[0]), 0);
        anim();
        pix(0, 380);   cmp("l0_wrap0", int'(obj[0]), 1);
        pix(639, 380); cmp("l0_wrap639", int'(obj[0]), 0);

        // Win sequence and hold period
        reset_dut();
        repeat (4) press(1, 0);
        cmp("win_pre_state", int'(state), 0);
        press(1, 0);
        cmp("win_state", int'(state), 2);
        cmp("win_score", int'(score), 1);
        anims(59);
        cmp("win_hold59", int'(state), 2);
        anim();
        cmp("win_back_play", int'(state), 0);
        cmp("win_score_kept", int'(score), 1);
        pix(312, 432); cmp("win_frog_row0", int'(frog), 1);

        // Collision in lane 0, frozen lanes, reset mid-HIT
        reset_dut();
        press(1, 0);
        anims(259);
        pix(312, 392); cmp("col_obj", int'(obj[0]), 1);
        cmp("col_frog", int'(frog), 1);
        anim();
        cmp("col_hit", int'(state), 1);
        anims(4);
        pix(261, 380); cmp("frozen_in", int'(obj[0]), 1);
        pix(260, 380); cmp("frozen_out", int'(obj[0]), 0);
        anims(26);
        cmp("hit_30", int'(state), 1);
        rst_n = 1'b0; step();
        cmp("midrst_state", int'(state), 0);
        cmp("midrst_score", int'(score), 0);
        rst_n = 1'b1; step();
        pix(312, 432); cmp("midrst_frog", int'(frog), 1);

        // Button edge cases
        reset_dut();
        press(1, 0); press(1, 0);
        set_btn(1, 1); idle(3); set_btn(0, 0); idle(3); anim();
        pix(312, 352); cmp("both_row2", int'(frog), 1);
        reset_dut();
        press(0, 1);
        pix(312, 432); cmp("down_row0", int'(frog), 1);
        reset_dut();
        set_btn(1, 0); idle(3); anims(3); set_btn(0, 0); idle(3); anim();
        pix(312, 392); cmp("held_row1", int'(frog), 1);
        pix(312, 352); cmp("held_not_row2", int'(frog), 0);

        // Randomised frames checked against the model
        reset_dut();
        repeat (400) begin
            animate = 1'b1; step(); animate = 1'b0;
            set_btn(($urandom % 3) == 0, ($urandom % 7) == 0);
            repeat (8) begin
                pix_stb = ($urandom % 4) != 0;
                if ($urandom % 2 == 0) begin
                    x = 10'(296 + $urandom % 48);
                    y = 9'(R0 - m_row * LH + $urandom % LH);
                end else begin
                    x = 10'($urandom % 640);
                    y = 9'($urandom % 480);
                end
                step();
            end
            pix_stb = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frogger_lanes.md
FROGGER_LANES -- requirements
Module: frogger_lanes

Interface
REQ-001 Parameter N_LANES, default 4: number of obstacle lanes, range 1-8.
REQ-002 Parameter LANE_H, default 40: height of a row in pixels.
REQ-003 Parameter ROW0_Y, default 420: top y of row 0, the start zone.
REQ-004 Parameter OBS_W, default 64: obstacle width in pixels.
REQ-005 Parameter SPEED_BASE, default 1: base speed in pixels per frame.
REQ-006 Parameter FROG_X, default 312: frog left x.
REQ-007 Parameter FROG_W, default 16: frog side length in pixels.
REQ-008 Parameter HOLD_FRAMES, default 60: number of frames the block holds in HIT or WIN.
REQ-009 Port i_clk, input, 1 bit: the single clock.
REQ-010 Port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-011 Port i_pix_stb, input, 1 bit: pixel strobe.
REQ-012 Port i_animate, input, 1 bit: one-cycle end-of-frame pulse.
REQ-013 Port i_x, input, 10 bits: current pixel x.
REQ-014 Port i_y, input, 9 bits: current pixel y.
REQ-015 Ports i_up_btn and i_down_btn, inputs, 1 bit each: asynchronous, active-high buttons.
REQ-016 Port o_obj, output, N_LANES bits: per-lane obstacle pixel hit.
REQ-017 Port o_frog, output, 1 bit: frog pixel hit.
REQ-018 Port o_state, output, 2 bits: state, PLAY=0, HIT=1, WIN=2.
REQ-019 Port o_score, output, 8 bits: win count.

Function
REQ-020 The block SHALL assign geometry as follows:
- Row r has top y = ROW0_Y - r*LANE_H.
- Lane k is row k+1.
- Row N_LANES+1 is the goal.
REQ-021 Lane k speed SHALL be SPEED_BASE*(k+1); even lanes SHALL move right (+x) and odd lanes left (-x).
REQ-022 Each lane SHALL hold a position cx in the range 0-639 with initial value (k*160) mod 640.
REQ-023 On each i_animate in PLAY, every lane SHALL update cx with wrap at 640:
- Right: cx+s >= 640 ? cx+s-640 : cx+s.
- Left: cx < s ? cx+640-s : cx-s.
REQ-024 Lane positions SHALL be frozen while the block is in HIT or WIN.
REQ-025 o_obj[k] SHALL be set when both hold:
- i_y lies within lane k's row band, inclusive.
- The distance dx = (i_x >= cx) ? i_x-cx : i_x+640-cx satisfies dx < OBS_W.
REQ-026 o_frog SHALL be set when both hold:
- i_x is in [FROG_X, FROG_X+FROG_W-1].
- i_y is in [top+(LANE_H-FROG_W)/2, same+FROG_W-1], where top is the frog's row top.
REQ-027 o_obj and o_frog SHALL be registered, updated only on cycles where i_pix_stb=1, with 1 i_clk latency.
REQ-028 Each button SHALL pass through a 2-flop synchroniser; a rising edge SHALL set a sticky pending flag.
REQ-029 Pending flags SHALL be consumed and cleared at the next i_animate, in any state.
REQ-030 Pending moves SHALL act only in PLAY, with these rules:
- Up: row+1.
- Down: row-1, except that down at row 0 causes no move.
- Both up and down pending: no move.
REQ-031 A collision flag SHALL be set on any i_pix_stb cycle where the frog-pixel and any lane-obstacle-pixel conditions are simultaneously true; it SHALL be cleared at every i_animate.
REQ-032 At i_animate in PLAY, the collision flag SHALL be evaluated before the move is applied:
- Flag set: go to HIT and discard the move.
- Otherwise, a move into the goal row: go to WIN, with o_score incremented and saturating at 255.
REQ-033 HIT and WIN SHALL count HOLD_FRAMES i_animate pulses, then set the frog row to 0, clear the counter and return to PLAY.

Reset
REQ-034 While i_rst_n=0 at a clock edge, the block SHALL reset as follows:
- o_state=PLAY.
- o_score=0.
- Frog row 0.
- cx to the initial values.
- o_obj=0 and o_frog=0.
- Hold counter, pending flags, collision flag and synchronisers cleared.
REQ-035 Reset SHALL override all activity, including a reset arriving mid-HIT or mid-WIN.

Structure
REQ-036 Shared package frogger_pkg SHALL hold the state encoding, H_RES=640 and the coordinate widths.
REQ-037 Sub-module lane_obstacle SHALL implement cx, wrap and the pixel compare for one lane, generated N_LANES times; the top-level block SHALL hold the frog, buttons, FSM and score.

Verification
REQ-038 Reset, then one i_animate: o_obj[0]=1 at (1,380) and 0 at (0,380); o_obj[1] is high at x=158-221 with y=340.
REQ-039 Wrap: with lane 0 cx=639, one i_animate gives cx=0; with lane 1 cx=1 (speed 2), one i_animate gives cx=639.
REQ-040 Win sequence: 5 up pulses spaced one frame apart give o_state=2 and o_score=1; after 60 i_animate pulses, o_state=0 and the frog is in row 0 (o_frog high at (312,432)).
REQ-041 Collision: with the frog in row 1 and a lane 0 obstacle overlapping x=312, the next i_animate gives o_state=1 and lanes frozen.
REQ-042 Button edge cases: up and down both pending at row 2 gives row 2 unchanged; down at row 0 gives row 0; a held button yields exactly one move.
REQ-043 Reset mid-operation: asserting i_rst_n=0 in HIT after 30 frames gives o_state=0, o_score unchanged at 0, and frog row 0 on the next clock.
